// File: rtl/loteria_pkg.sv
// rtl/loteria_pkg.sv - shared state encoding, prize codes and digit helpers for the lottery arbiter
package loteria_pkg;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_CHECK = 2'd1;
    localparam state_t ST_DONE  = 2'd2;
    localparam state_t ST_HOLD  = 2'd3;

    typedef logic [1:0] prize_t;
    localparam prize_t PRIZE_NONE    = 2'b00;
    localparam prize_t PRIZE_1       = 2'b01;
    localparam prize_t PRIZE_2       = 2'b10;
    localparam prize_t PRIZE_INVALID = 2'b11;

    localparam logic [3:0]  BCD_MAX     = 4'd9;
    localparam logic [19:0] WIN_DEFAULT = 20'h50967;

    // Digit 0 is the most significant nibble of the 20-bit ticket.
    function automatic logic [3:0] digit_of(input logic [19:0] value, input logic [2:0] idx);
        case (idx)
            3'd0:    digit_of = value[19:16];
            3'd1:    digit_of = value[15:12];
            3'd2:    digit_of = value[11:8];
            3'd3:    digit_of = value[7:4];
            default: digit_of = value[3:0];
        endcase
    endfunction

    function automatic prize_t decide_prize(input logic invalid, input logic [2:0] hits);
        if (invalid)
            decide_prize = PRIZE_INVALID;
        else if (hits >= 3'd4)
            decide_prize = PRIZE_1;
        else if (hits == 3'd3)
            decide_prize = PRIZE_2;
        else
            decide_prize = PRIZE_NONE;
    endfunction

endpackage

// File: rtl/loteria_verificador.sv
// rtl/loteria_verificador.sv - serial BCD digit comparator accumulating hit count and sticky invalid flag
module loteria_verificador
    import loteria_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic [3:0] digit,
    input  logic [3:0] expected,
    output logic [2:0] hits,
    output logic       invalid
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hits    <= 3'd0;
            invalid <= 1'b0;
        end else if (clr) begin
            hits    <= 3'd0;
            invalid <= 1'b0;
        end else if (en) begin
            if (digit > BCD_MAX)
                invalid <= 1'b1;
            if (digit == expected)
                hits <= hits + 3'd1;
        end
    end

endmodule

// File: rtl/loteria_arbitro.sv
// rtl/loteria_arbitro.sv - round-robin ticket checker shared by N_TERM terminals; LOTERIA_ESTAT_EN adds statistics counters
module loteria_arbitro
    import loteria_pkg::*;
#(
    parameter int          N_TERM = 4,
    parameter logic [19:0] WIN    = WIN_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_TERM-1:0]         req,
    input  logic [20*N_TERM-1:0]      ticket,
    output logic [N_TERM-1:0]         ack,
    output logic [1:0]                prize,
    output logic [$clog2(N_TERM)-1:0] grant_id,
    output logic                      busy
`ifdef LOTERIA_ESTAT_EN
    ,
    output logic [7:0]                tickets_total,
    output logic [7:0]                wins_total
`endif
);

    localparam int GW = $clog2(N_TERM);

    state_t        state;
    logic [19:0]   held_ticket;
    logic [2:0]    digit_idx;
    logic [GW-1:0] next_id;
    logic [19:0]   sel_ticket;
    logic [GW:0]   wide;
    logic          found;
    logic [2:0]    hits;
    logic          invalid;
    prize_t        result;
    logic          grant;

    // Round-robin search starting one past the last served terminal.
    always_comb begin
        next_id = grant_id;
        found   = 1'b0;
        wide    = '0;
        for (int k = 1; k <= N_TERM; k++) begin
            wide = {1'b0, grant_id} + (GW+1)'(k);
            if (wide >= (GW+1)'(N_TERM))
                wide = wide - (GW+1)'(N_TERM);
            if (!found && req[wide[GW-1:0]]) begin
                found   = 1'b1;
                next_id = wide[GW-1:0];
            end
        end
    end

    always_comb begin
        sel_ticket = '0;
        for (int k = 0; k < N_TERM; k++) begin
            if (next_id == GW'(k))
                sel_ticket = ticket[20*k +: 20];
        end
    end

    assign grant  = (state == ST_IDLE) && (|req);
    assign busy   = (state != ST_IDLE);
    assign result = decide_prize(invalid, hits);

    loteria_verificador u_verificador (
        .clk      (clk),
        .reset    (reset),
        .clr      (grant),
        .en       (state == ST_CHECK),
        .digit    (digit_of(held_ticket, digit_idx)),
        .expected (digit_of(WIN, digit_idx)),
        .hits     (hits),
        .invalid  (invalid)
    );

    // ack and prize are registered on the edge leaving DONE, so they appear during the first HOLD cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            ack         <= '0;
            prize       <= PRIZE_NONE;
            grant_id    <= GW'(N_TERM-1);
            held_ticket <= '0;
            digit_idx   <= 3'd0;
        end else begin
            ack <= '0;
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        grant_id    <= next_id;
                        held_ticket <= sel_ticket;
                        digit_idx   <= 3'd0;
                        state       <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    digit_idx <= digit_idx + 3'd1;
                    if (digit_idx == 3'd4)
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    ack   <= N_TERM'(1) << grant_id;
                    prize <= result;
                    state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (!req[grant_id])
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef LOTERIA_ESTAT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tickets_total <= 8'd0;
            wins_total    <= 8'd0;
        end else if (state == ST_DONE) begin
            if (tickets_total != 8'hFF)
                tickets_total <= tickets_total + 8'd1;
            if ((result == PRIZE_1 || result == PRIZE_2) && wins_total != 8'hFF)
                wins_total <= wins_total + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_loteria_arbitro.sv
// tb/tb_loteria_arbitro.sv - randomized and directed bench with a cycle-count reference model for loteria_arbitro
module tb_loteria_arbitro;

    localparam int          N = 4;
    localparam logic [19:0] W = 20'h50967;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req = '0;
    logic [20*N-1:0] ticket = '0;
    logic [N-1:0]   ack;
    logic [1:0]     prize;
    logic [1:0]     grant_id;
    logic           busy;
`ifdef LOTERIA_ESTAT_EN
    logic [7:0]     tickets_total;
    logic [7:0]     wins_total;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    loteria_arbitro #(.N_TERM(N), .WIN(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .ticket   (ticket),
        .ack      (ack),
        .prize    (prize),
        .grant_id (grant_id),
        .busy     (busy)
`ifdef LOTERIA_ESTAT_EN
        ,
        .tickets_total (tickets_total),
        .wins_total    (wins_total)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] model_prize(input logic [19:0] t);
        int hits;
        bit bad;
        logic [3:0] d;
        logic [3:0] w;
        hits = 0;
        bad  = 0;
        for (int i = 0; i < 5; i++) begin
            d = 4'(t >> (16 - 4*i));
            w = 4'(W >> (16 - 4*i));
            if (d > 4'd9) bad = 1;
            if (d == w) hits++;
        end
        if (bad) return 2'b11;
        if (hits >= 4) return 2'b01;
        if (hits == 3) return 2'b10;
        return 2'b00;
    endfunction

    // Reference: grant, then ack exactly 6 edges later, then release once the winner drops req.
    bit          m_busy = 0;
    int          m_cnt = 0;
    int          m_last = N-1;
    logic [N-1:0] m_ack = '0;
    logic [1:0]  m_prize = 2'b00;
    logic [19:0] m_tkt = '0;
    int          m_tickets = 0;
    int          m_wins = 0;

    initial begin
        int  win;
        bit  got;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_busy = 0; m_last = N-1; m_ack = '0; m_prize = 2'b00;
                m_tickets = 0; m_wins = 0; m_cnt = 0;
            end else begin
                m_ack = '0;
                if (!m_busy) begin
                    if (req != 0) begin
                        got = 0;
                        win = 0;
                        for (int k = 1; k <= N; k++) begin
                            if (!got && req[(m_last + k) % N]) begin
                                got = 1;
                                win = (m_last + k) % N;
                            end
                        end
                        m_last = win;
                        m_tkt  = ticket[20*win +: 20];
                        m_busy = 1;
                        m_cnt  = 0;
                    end
                end else begin
                    m_cnt++;
                    if (m_cnt == 6) begin
                        m_ack   = N'(1) << m_last;
                        m_prize = model_prize(m_tkt);
                        if (m_tickets < 255) m_tickets++;
                        if ((m_prize == 2'b01 || m_prize == 2'b10) && m_wins < 255) m_wins++;
                    end else if (m_cnt > 6 && !req[m_last]) begin
                        m_busy = 0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("cmp_ack", ack, m_ack);
                check("cmp_busy", busy, m_busy);
                check("cmp_grant_id", grant_id, m_last);
                if (m_ack != 0) check("cmp_prize", prize, m_prize);
`ifdef LOTERIA_ESTAT_EN
                check("cmp_tickets_total", tickets_total, m_tickets);
                check("cmp_wins_total", wins_total, m_wins);
`endif
            end
        end
    end

    task automatic wait_ack(input int budget, output int cycles, output bit ok);
        cycles = 0;
        ok = 0;
        while (!ok && cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (ack != 0) ok = 1;
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle_timeout"}, busy, 0);
    endtask

    task automatic do_reset();
        req = '0;
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic serve(input int t, input logic [19:0] tk, input logic [1:0] exp_p,
                         input int hold, input string name);
        int cyc;
        bit ok;
        @(negedge clk);
        ticket[20*t +: 20] = tk;
        req[t] = 1'b1;
        @(negedge clk);
        ticket[20*t +: 20] = 20'hFFFFF;
        wait_ack(20, cyc, ok);
        cyc++;
        check({name, "_seen"}, ok, 1);
        check({name, "_latency"}, cyc, 7);
        check({name, "_ack"}, ack, N'(1) << t);
        check({name, "_prize"}, prize, exp_p);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({name, "_hold_busy"}, busy, 1);
            check({name, "_hold_ack"}, ack, 0);
        end
        req[t] = 1'b0;
        @(negedge clk);
        check({name, "_released"}, busy, 0);
    endtask

    function automatic logic [19:0] rand_ticket();
        logic [19:0] t;
        int r;
        t = '0;
        for (int i = 0; i < 5; i++) begin
            r = $urandom_range(0, 15);
            t = t << 4;
            if (r < 8)       t[3:0] = 4'(W >> (16 - 4*i));
            else if (r < 14) t[3:0] = 4'($urandom_range(0, 9));
            else             t[3:0] = 4'($urandom_range(10, 15));
        end
        return t;
    endfunction

    initial begin
        int  cyc;
        bit  ok;
        int  order [5];
        int  id;
        order = '{0, 1, 2, 3, 0};

        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("rst_ack", ack, 0);
        check("rst_busy", busy, 0);
        check("rst_grant_id", grant_id, N-1);
        check("rst_prize", prize, 2'b00);

        serve(0, 20'h50967, 2'b01, 3, "basic");
        serve(0, 20'h50960, 2'b01, 0, "four_hits");
        serve(0, 20'h50900, 2'b10, 0, "three_hits");
        serve(0, 20'h12345, 2'b00, 0, "no_hits");
        serve(0, 20'h5A967, 2'b11, 0, "invalid");
        serve(2, 20'h50967, 2'b01, 1, "term2");

        do_reset();
        @(negedge clk);
        req = '1;
        for (int k = 0; k < 5; k++) begin
            wait_ack(30, cyc, ok);
            check("rr_seen", ok, 1);
            check("rr_order", ack, N'(1) << order[k]);
            req = req & ~ack;
            @(negedge clk);
            req = '1;
        end
        req = '0;
        wait_idle("rr");

        @(negedge clk);
        ticket[19:0] = 20'h50900;
        req[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        req[0] = 1'b0;
        wait_ack(20, cyc, ok);
        check("drop_seen", ok, 1);
        check("drop_ack", ack, 1);
        check("drop_prize", prize, 2'b10);
        @(negedge clk);
        check("drop_idle", busy, 0);

        @(negedge clk);
        ticket[19:0] = 20'h50967;
        req[0] = 1'b1;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_ack", ack, 0);
        check("midrst_busy", busy, 0);
        check("midrst_grant_id", grant_id, N-1);
        check("midrst_prize", prize, 2'b00);
`ifdef LOTERIA_ESTAT_EN
        check("midrst_tickets", tickets_total, 0);
        check("midrst_wins", wins_total, 0);
`endif
        req[0] = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        wait_ack(10, cyc, ok);
        check("midrst_no_ack", ok, 0);
        serve(0, 20'h50967, 2'b01, 0, "after_rst");

        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
                if ($urandom_range(0, 3) == 0) ticket[20*i +: 20] = rand_ticket();
            end
        end
        req = '0;
        wait_idle("random");
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
